// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and helpers for the convolution sequencer.
//               Holds the FSM state encoding, the default address width
//               and small elaboration-time helpers used to size counters.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Default address width for all memory address ports.
    localparam int CONV_ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Output image side length for a "valid" (no padding) convolution.
    function automatic int out_width(input int img_w, input int k);
        return img_w - k + 1;
    endfunction

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_addr_gen
// Description : Nested pixel/tap counters and address decoders for the
//               convolution sequencer.
//   clk, rst        : clock, synchronous active-high reset
//   clear           : zero all four counters
//   tap_step        : advance kc, wrapping into kr (tap loop)
//   pix_step        : advance ocol, wrapping into orow (pixel loop)
//   xb, yb, zb      : latched base addresses (image, filter, output)
//   last_tap        : current tap is (K-1, K-1)
//   last_pix        : current pixel is (OUT_W-1, OUT_W-1)
//   in_addr         : xb + (orow+kr)*IMG_W + (ocol+kc)
//   flt_addr        : yb + kr*K + kc
//   out_addr        : zb + orow*OUT_W + ocol
// Revision    : 1.0 - initial release
// ============================================================================
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 6,
    parameter int K      = 3,
    parameter int ADDR_W = CONV_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              tap_step,
    input  logic              pix_step,
    input  logic [ADDR_W-1:0] xb,
    input  logic [ADDR_W-1:0] yb,
    input  logic [ADDR_W-1:0] zb,
    output logic              last_tap,
    output logic              last_pix,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] flt_addr,
    output logic [ADDR_W-1:0] out_addr
);

    localparam int OUT_W = out_width(IMG_W, K);
    localparam int KW    = cnt_width(K);
    localparam int PW    = cnt_width(OUT_W);

    localparam logic [KW-1:0] K_LAST   = KW'(K - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(OUT_W - 1);

    logic [KW-1:0] kr_q,   kr_d;
    logic [KW-1:0] kc_q,   kc_d;
    logic [PW-1:0] orow_q, orow_d;
    logic [PW-1:0] ocol_q, ocol_d;

    always_comb begin
        kr_d   = kr_q;
        kc_d   = kc_q;
        orow_d = orow_q;
        ocol_d = ocol_q;
        if (clear) begin
            kr_d   = '0;
            kc_d   = '0;
            orow_d = '0;
            ocol_d = '0;
        end else begin
            // Stepping past the final tap returns both tap counters to 0,
            // so the next pixel always starts at tap (0,0).
            if (tap_step) begin
                if (kc_q == K_LAST) begin
                    kc_d = '0;
                    kr_d = (kr_q == K_LAST) ? '0 : kr_q + KW'(1);
                end else begin
                    kc_d = kc_q + KW'(1);
                end
            end
            if (pix_step) begin
                if (ocol_q == PIX_LAST) begin
                    ocol_d = '0;
                    orow_d = (orow_q == PIX_LAST) ? '0 : orow_q + PW'(1);
                end else begin
                    ocol_d = ocol_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kr_q   <= '0;
            kc_q   <= '0;
            orow_q <= '0;
            ocol_q <= '0;
        end else begin
            kr_q   <= kr_d;
            kc_q   <= kc_d;
            orow_q <= orow_d;
            ocol_q <= ocol_d;
        end
    end

    assign last_tap = (kr_q == K_LAST) && (kc_q == K_LAST);
    assign last_pix = (orow_q == PIX_LAST) && (ocol_q == PIX_LAST);

    // All arithmetic is carried out at ADDR_W bits so overflow wraps
    // silently modulo 2^ADDR_W.
    logic [ADDR_W-1:0] row_sum;
    assign row_sum  = ADDR_W'(orow_q) + ADDR_W'(kr_q);
    assign in_addr  = xb + row_sum * ADDR_W'(IMG_W) + ADDR_W'(ocol_q) + ADDR_W'(kc_q);
    assign flt_addr = yb + ADDR_W'(kr_q) * ADDR_W'(K) + ADDR_W'(kc_q);
    assign out_addr = zb + ADDR_W'(orow_q) * ADDR_W'(OUT_W) + ADDR_W'(ocol_q);

endmodule : conv_addr_gen
`default_nettype wire

// File: rtl/conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_ctrl
// Description : Sequencing controller for the convolution datapath. On a
//               start pulse it latches the three base addresses, then walks
//               every output pixel and every filter tap, driving memory read
//               addresses, MAC strobes and output writes, and pulses done.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a run (sampled only in IDLE)
//   x, y, z    : image, filter and output base addresses
//   done       : one-cycle completion pulse
//   busy       : high in every state except IDLE
//   in_addr    : image memory read address
//   flt_addr   : filter memory read address
//   out_addr   : output memory write address
//   mac_clr    : clear accumulator
//   mac_en     : accumulate current read data
//   out_we     : write accumulator to out_addr
// Revision    : 1.0 - initial release
// ============================================================================
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W  = 6,
    parameter int K      = 3,
    parameter int ADDR_W = CONV_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] x,
    input  logic [ADDR_W-1:0] y,
    input  logic [ADDR_W-1:0] z,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] flt_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              out_we
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] xb_q, xb_d;
    logic [ADDR_W-1:0] yb_q, yb_d;
    logic [ADDR_W-1:0] zb_q, zb_d;
    logic              mac_en_q, mac_en_d;

    logic cnt_clear;
    logic tap_step;
    logic pix_step;
    logic last_tap;
    logic last_pix;

    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .K      (K),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .tap_step (tap_step),
        .pix_step (pix_step),
        .xb       (xb_q),
        .yb       (yb_q),
        .zb       (zb_q),
        .last_tap (last_tap),
        .last_pix (last_pix),
        .in_addr  (in_addr),
        .flt_addr (flt_addr),
        .out_addr (out_addr)
    );

    // Next-state and strobe decode.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        done      = 1'b0;
        mac_clr   = 1'b0;
        out_we    = 1'b0;
        cnt_clear = 1'b0;
        tap_step  = 1'b0;
        pix_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                cnt_clear = 1'b1;
                mac_clr   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_FETCH: begin
                tap_step = 1'b1;
                if (last_tap) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Covers the read latency of the final tap of the pixel.
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // The datapath writes the old accumulator before clearing it,
                // so write and clear share this cycle.
                out_we   = 1'b1;
                mac_clr  = 1'b1;
                pix_step = 1'b1;
                state_d  = last_pix ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bases are captured from the ports during INIT; they ignore x/y/z for
    // the remainder of the run.
    always_comb begin
        xb_d = xb_q;
        yb_d = yb_q;
        zb_d = zb_q;
        if (state_q == ST_INIT) begin
            xb_d = x;
            yb_d = y;
            zb_d = z;
        end
    end

    // Memories have one-cycle read latency, so the accumulate strobe trails
    // each FETCH cycle by one clock.
    assign mac_en_d = (state_q == ST_FETCH);
    assign mac_en   = mac_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            xb_q     <= '0;
            yb_q     <= '0;
            zb_q     <= '0;
            mac_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            xb_q     <= xb_d;
            yb_q     <= yb_d;
            zb_q     <= zb_d;
            mac_en_q <= mac_en_d;
        end
    end

endmodule : conv_ctrl
`default_nettype wire

// File: tb/tb_conv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_ctrl
// Description : Self-checking bench for conv_ctrl. Each run's expected
//               fetch addresses, MAC strobes, writes and done pulse are
//               queued with their cycle numbers when start is driven and
//               popped by a negedge monitor as the cycles arrive.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_ctrl;

    localparam int IMG_W = 6;
    localparam int K     = 3;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int STEP  = K * K + 2;

    typedef struct {
        int         t;
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] x, y, z;
    logic       done, busy, mac_clr, mac_en, out_we;
    logic [7:0] in_addr, flt_addr, out_addr;

    int  cyc    = 0;
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  n_done = 0;
    bit  mon_en = 1'b0;

    ev_t exp_fetch[$];
    ev_t exp_wr[$];
    int  exp_mac[$];
    int  exp_clr[$];
    int  exp_done[$];

    conv_ctrl #(
        .IMG_W  (IMG_W),
        .K      (K),
        .ADDR_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x        (x),
        .y        (y),
        .z        (z),
        .done     (done),
        .busy     (busy),
        .in_addr  (in_addr),
        .flt_addr (flt_addr),
        .out_addr (out_addr),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .out_we   (out_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Queue the full expected trace of a run whose start is sampled at the
    // edge ending cycle t0 (so INIT is cycle t0+1).
    task automatic push_run(input int t0, input logic [7:0] xb, input logic [7:0] yb,
                            input logic [7:0] zb);
        ev_t e;
        exp_clr.push_back(t0 + 1);
        for (int p = 0; p < OUT_W * OUT_W; p++) begin
            for (int t = 0; t < K * K; t++) begin
                e.t = t0 + 2 + p * STEP + t;
                e.a = 8'(int'(xb) + ((p / OUT_W) + (t / K)) * IMG_W + (p % OUT_W) + (t % K));
                e.b = 8'(int'(yb) + (t / K) * K + (t % K));
                exp_fetch.push_back(e);
                exp_mac.push_back(e.t + 1);
            end
            e.t = t0 + 1 + (p + 1) * STEP;
            e.a = 8'(int'(zb) + p);
            e.b = 8'd0;
            exp_wr.push_back(e);
            exp_clr.push_back(e.t);
        end
        exp_done.push_back(t0 + 2 + OUT_W * OUT_W * STEP);
    endtask

    // Scoreboard monitor.
    bit  m_ex;
    ev_t m_e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_fetch.size() > 0 && exp_fetch[0].t == cyc) begin
                m_e = exp_fetch.pop_front();
                n_cmp++;
                if (in_addr !== m_e.a || flt_addr !== m_e.b) begin
                    n_fail++;
                    $display("FAIL fetch @%0d: in_addr=%0d flt_addr=%0d, required %0d/%0d",
                             cyc, in_addr, flt_addr, m_e.a, m_e.b);
                end
            end
            m_ex = (exp_mac.size() > 0 && exp_mac[0] == cyc);
            if (m_ex || mac_en !== 1'b0) begin
                n_cmp++;
                if (mac_en !== m_ex) begin
                    n_fail++;
                    $display("FAIL mac_en @%0d: got %b, required %b", cyc, mac_en, m_ex);
                end
                if (m_ex) void'(exp_mac.pop_front());
            end
            m_ex = (exp_clr.size() > 0 && exp_clr[0] == cyc);
            if (m_ex || mac_clr !== 1'b0) begin
                n_cmp++;
                if (mac_clr !== m_ex) begin
                    n_fail++;
                    $display("FAIL mac_clr @%0d: got %b, required %b", cyc, mac_clr, m_ex);
                end
                if (m_ex) void'(exp_clr.pop_front());
            end
            m_ex = (exp_wr.size() > 0 && exp_wr[0].t == cyc);
            if (m_ex || out_we !== 1'b0) begin
                n_cmp++;
                if (out_we !== m_ex) begin
                    n_fail++;
                    $display("FAIL out_we @%0d: got %b, required %b", cyc, out_we, m_ex);
                end else if (m_ex && out_addr !== exp_wr[0].a) begin
                    n_fail++;
                    $display("FAIL out_addr @%0d: got %0d, required %0d", cyc, out_addr, exp_wr[0].a);
                end
                if (m_ex) void'(exp_wr.pop_front());
            end
            m_ex = (exp_done.size() > 0 && exp_done[0] == cyc);
            if (done === 1'b1) n_done++;
            if (m_ex || done !== 1'b0) begin
                n_cmp++;
                if (done !== m_ex) begin
                    n_fail++;
                    $display("FAIL done @%0d: got %b, required %b", cyc, done, m_ex);
                end
                if (m_ex) void'(exp_done.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; x = 8'd16; y = 8'd0; z = 8'd64;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, mac_en, mac_clr, out_we} !== 5'b0 || in_addr !== 8'd0 ||
            flt_addr !== 8'd0 || out_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy/done/en/clr/we=%b%b%b%b%b addrs=%0d/%0d/%0d, required all 0",
                     busy, done, mac_en, mac_clr, out_we, in_addr, flt_addr, out_addr);
        end
        #1; rst = 1'b0; start = 1'b0;
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: busy=%b, required 0", busy);
            end
        end
    endtask

    task automatic test_basic_run();
        int t0;
        int d0;
        @(negedge clk); #1;
        t0 = cyc; d0 = n_done;
        x = 8'd16; y = 8'd0; z = 8'd64; start = 1'b1;
        push_run(t0, x, y, z);
        @(negedge clk); #1;
        start = 1'b0;
        wait_cyc(t0 + 178);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done178: done=%b busy=%b, required 1/1", done, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_fall: busy=%b done=%b, required 0/0", busy, done);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (n_done - d0 !== 1) begin
            n_fail++;
            $display("FAIL basic_done_count: got %0d, required 1", n_done - d0);
        end
    endtask

    task automatic test_handshake();
        int t0;
        int d0;
        @(negedge clk); #1;
        t0 = cyc; d0 = n_done;
        x = 8'd32; y = 8'd100; z = 8'd200; start = 1'b1;
        push_run(t0, x, y, z);
        wait_cyc(t0 + 100); #1;
        // New bases mid-run: ignored by run 1, latched by run 2.
        x = 8'd0; y = 8'd50; z = 8'd10;
        push_run(t0 + 179, x, y, z);
        wait_cyc(t0 + 179);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_idle179: busy=%b, required 0", busy);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_init180: busy=%b, required 1", busy);
        end
        wait_cyc(t0 + 300); #1;
        start = 1'b0;
        wait_cyc(t0 + 179 + 180);
        n_cmp++;
        if (busy !== 1'b0 || n_done - d0 !== 2) begin
            n_fail++;
            $display("FAIL hs_two_runs: busy=%b dones=%0d, required 0/2", busy, n_done - d0);
        end
    endtask

    task automatic test_wrap();
        int t0;
        @(negedge clk); #1;
        t0 = cyc;
        x = 8'd250; y = 8'd10; z = 8'd254; start = 1'b1;
        push_run(t0, x, y, z);
        @(negedge clk); #1;
        start = 1'b0;
        wait_cyc(t0 + 10);
        n_cmp++;
        if (in_addr !== 8'd8) begin
            n_fail++;
            $display("FAIL wrap_in_addr: got %0d, required 8", in_addr);
        end
        wait_cyc(t0 + 1 + 3 * STEP);
        n_cmp++;
        if (out_we !== 1'b1 || out_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_out_addr: we=%b addr=%0d, required 1/0", out_we, out_addr);
        end
        wait_cyc(t0 + 182);
    endtask

    task automatic test_mid_reset();
        int t0;
        int d0;
        int lim;
        @(negedge clk); #1;
        t0 = cyc; d0 = n_done;
        x = 8'd16; y = 8'd0; z = 8'd64; start = 1'b1;
        push_run(t0, x, y, z);
        @(negedge clk); #1;
        start = 1'b0;
        wait_cyc(t0 + 50); #1;
        rst = 1'b1;
        lim = t0 + 50;
        while (exp_fetch.size() > 0 && exp_fetch[$].t > lim) void'(exp_fetch.pop_back());
        while (exp_wr.size() > 0 && exp_wr[$].t > lim) void'(exp_wr.pop_back());
        while (exp_mac.size() > 0 && exp_mac[$] > lim) void'(exp_mac.pop_back());
        while (exp_clr.size() > 0 && exp_clr[$] > lim) void'(exp_clr.pop_back());
        while (exp_done.size() > 0 && exp_done[$] > lim) void'(exp_done.pop_back());
        wait_cyc(t0 + 51);
        n_cmp++;
        if ({busy, done, mac_en, mac_clr, out_we} !== 5'b0 || in_addr !== 8'd0 ||
            flt_addr !== 8'd0 || out_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: busy/done/en/clr/we=%b%b%b%b%b addrs=%0d/%0d/%0d, required all 0",
                     busy, done, mac_en, mac_clr, out_we, in_addr, flt_addr, out_addr);
        end
        #1; rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (n_done !== d0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_abort: dones=%0d busy=%b, required 0/0", n_done - d0, busy);
        end
        #1;
        t0 = cyc;
        x = 8'd40; y = 8'd20; z = 8'd128; start = 1'b1;
        push_run(t0, x, y, z);
        @(negedge clk); #1;
        start = 1'b0;
        wait_cyc(t0 + 178);
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_rerun_done: done=%b at cycle 178, required 1", done);
        end
        wait_cyc(t0 + 182);
        n_cmp++;
        if (n_done - d0 !== 1) begin
            n_fail++;
            $display("FAIL midrst_rerun_count: got %0d, required 1", n_done - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_handshake();
        test_wrap();
        test_mid_reset();
        n_cmp++;
        if (exp_fetch.size() + exp_wr.size() + exp_mac.size() + exp_clr.size() + exp_done.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expectations: got %0d, required 0",
                     exp_fetch.size() + exp_wr.size() + exp_mac.size() + exp_clr.size() + exp_done.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_conv_ctrl
`default_nettype wire

// File: doc/conv_ctrl.md
Name: conv_ctrl

Overview:
- Sequencing controller for the convolution datapath: takes a start pulse plus three 8-bit base addresses (x = input image, y = filter, z = output).
- Walks every output pixel and every filter tap. Drives read addresses to input and filter memories, MAC clear/enable strobes, and output write address/enable; pulses done at the end.
- Sits between the top-level start/done interface and the MAC/memory datapath.

Parameters:
- IMG_W, 6, input image width = height (square, row-major at base x).
- K, 3, filter width = height (square, row-major at base y).
- ADDR_W, 8, address width; all address arithmetic is modulo 2^ADDR_W.
- Derived constant OUT_W = IMG_W-K+1 (default 4): output is square, row-major at base z.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- x  in  ADDR_W  input image base address.
- y  in  ADDR_W  filter base address.
- z  in  ADDR_W  output base address.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- in_addr  out  ADDR_W  input memory read address.
- flt_addr  out  ADDR_W  filter memory read address.
- out_addr  out  ADDR_W  output memory write address.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate the current read data (memories have 1-cycle synchronous read).
- out_we  out  1  write accumulator to out_addr.

Behaviour:
- Reset: synchronous, active-high, dominates all else. State goes to IDLE; all counters, latched bases and every output go to 0 on the next edge. Reset mid-run aborts with no done pulse.
- Counters: orow and ocol in 0..OUT_W-1; kr and kc in 0..K-1. Bases xb, yb, zb are latched on start; x, y, z are ignored afterwards.
- States:
  - IDLE: busy=0. If start=1, go to INIT, otherwise stay.
  - INIT: latch xb/yb/zb, clear all counters, mac_clr=1. Go to FETCH.
  - FETCH: in_addr = xb+(orow+kr)*IMG_W+(ocol+kc); flt_addr = yb+kr*K+kc. Advance kc; on wrap, advance kr. After tap (K-1,K-1), reset kr/kc and go to DRAIN. Otherwise stay.
  - DRAIN: one cycle for the last tap's read latency. Go to WRITE.
  - WRITE: out_we=1, out_addr = zb+orow*OUT_W+ocol. mac_clr=1 in the same cycle; the datapath writes the old accumulator value, then clears. Advance ocol; on wrap, advance orow. After pixel (OUT_W-1,OUT_W-1) go to DONE, otherwise go to FETCH.
  - DONE: done=1 for exactly one cycle. Go to IDLE.
- mac_en is a register set when the state is FETCH. It is high during the cycle after each FETCH cycle (FETCH cycles 2..K² and DRAIN), giving exactly K² pulses per pixel.
- Address outputs are registered-state combinational decodes. They hold value (not forced to 0) outside their strobe cycles, except after reset.
- Latency, counting the cycle after start is sampled as cycle 1:
  - pixel p is written in cycle 1+(p+1)*(K²+2);
  - done fires in cycle 2+OUT_W²*(K²+2), which is 178 for the defaults.
- start while busy is ignored. If start is still high in IDLE after DONE, a new run begins immediately.
- Address overflow wraps modulo 2^ADDR_W with no error flag.

Decomposition:
- conv_pkg holds:
  - the state enum (IDLE, INIT, FETCH, DRAIN, WRITE, DONE);
  - the default ADDR_W;
  - an OUT_W helper function.
- One natural sub-module, conv_addr_gen, holds the four nested counters and the three address computations. Its controls are clear, tap_step and pix_step; its outputs are last_tap, last_pix and the addresses. conv_ctrl keeps the FSM and strobes.

Test Plan:
1. Reset: rst=1 for 2 cycles with start=1 -> all outputs 0, busy=0, state IDLE; no run starts until after rst drops.
2. Basic run, x=16, y=0, z=64, 1-cycle start:
   - first FETCH: in_addr=16, flt_addr=0;
   - 9th FETCH: in_addr=30, flt_addr=8;
   - mac_en high for exactly 9 cycles per pixel;
   - first out_we in cycle 12 with out_addr=64;
   - 16 out_we pulses total, last out_addr=79;
   - done single pulse in cycle 178, busy falls the cycle after.
3. Pixel indexing, same run: pixel 1 first in_addr=17; pixel 4 (orow=1, ocol=0) first in_addr=22; pixel 15 last in_addr=16+5*6+5=51.
4. Handshake: start held high for 300 cycles -> run 1 done in cycle 178, run 2 INIT in cycle 180 with freshly latched x/y/z. Changing x mid-run has no effect on in_addr.
5. Wrap-around: x=250 -> pixel 0 last tap in_addr=(250+14) mod 256 = 8; z=254 -> pixel 2 out_addr=0.
6. Reset mid-run: assert rst in cycle 50 -> next cycle all outputs 0, busy=0, no done. A new start then completes a full run with done exactly 178 cycles later.
